// File: rtl/apb_slave_mem.sv
// APB completer with a byte-wide register file, programmable wait states and PSLVERR on out-of-range addresses.
// Optional feature: define APB_SLV_RO_REGION_EN to make RO_BASE..MEM_DEPTH-1 read-only (writes there error out).
module apb_slave_mem #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int MEM_DEPTH   = 128,
    parameter int WAIT_STATES = 0,
    parameter int RO_BASE     = 96
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic                  PREADY,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PSLVERR
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0] RO_L    = (ADDR_WIDTH + 1)'(RO_BASE);
    localparam logic [3:0]          WS_L    = 4'(WAIT_STATES);
`ifdef APB_SLV_RO_REGION_EN
    localparam logic RO_EN = 1'b1;
`else
    localparam logic RO_EN = 1'b0;
`endif

    typedef enum logic [0:0] {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    state_t                state_r, state_nxt_s;
    logic [3:0]            cnt_r, cnt_nxt_s;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic                  write_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic                  pready_r, pslverr_r;
    logic [DATA_WIDTH-1:0] prdata_r;
    logic [DATA_WIDTH-1:0] mem_r [MEM_DEPTH];

    logic                  latch_s, set_rsp_s, clr_rsp_s, commit_s;
    logic [ADDR_WIDTH-1:0] eff_addr_s;
    logic                  eff_write_s, err_s;
    logic [DATA_WIDTH-1:0] rd_data_s;

    // With zero wait states the response is built at the setup edge, so use the live bus there.
    assign eff_addr_s  = latch_s ? PADDR  : addr_r;
    assign eff_write_s = latch_s ? PWRITE : write_r;
    assign err_s       = ({1'b0, eff_addr_s} >= DEPTH_L) |
                         (RO_EN & eff_write_s & ({1'b0, eff_addr_s} >= RO_L));
    assign rd_data_s   = (eff_write_s | err_s) ? '0 : mem_r[eff_addr_s[IDX_W-1:0]];

    // Next-state and per-edge action decode.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        latch_s     = 1'b0;
        set_rsp_s   = 1'b0;
        clr_rsp_s   = 1'b0;
        commit_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_nxt_s = ACCESS;
                    latch_s     = 1'b1;
                    cnt_nxt_s   = WS_L;
                    set_rsp_s   = (WS_L == 4'd0);
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    state_nxt_s = IDLE;
                    clr_rsp_s   = 1'b1;
                end else if (!PENABLE) begin
                    state_nxt_s = ACCESS;
                end else if (pready_r) begin
                    // pslverr_r already holds this transfer's error status
                    commit_s    = write_r & ~pslverr_r;
                    clr_rsp_s   = 1'b1;
                    state_nxt_s = IDLE;
                end else if (cnt_r > 4'd1) begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end else begin
                    cnt_nxt_s = 4'd0;
                    set_rsp_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                clr_rsp_s   = 1'b1;
            end
        endcase
    end

    // State, latched transfer fields and registered response.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_r   <= IDLE;
            cnt_r     <= 4'd0;
            addr_r    <= '0;
            write_r   <= 1'b0;
            wdata_r   <= '0;
            pready_r  <= 1'b0;
            prdata_r  <= '0;
            pslverr_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            if (latch_s) begin
                addr_r  <= PADDR;
                write_r <= PWRITE;
                wdata_r <= PWDATA;
            end
            if (set_rsp_s) begin
                pready_r  <= 1'b1;
                prdata_r  <= rd_data_s;
                pslverr_r <= err_s;
            end else if (clr_rsp_s) begin
                pready_r  <= 1'b0;
                prdata_r  <= '0;
                pslverr_r <= 1'b0;
            end
        end
    end

    // Register file; writes land only on a clean completion edge.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (commit_s) begin
            mem_r[addr_r[IDX_W-1:0]] <= wdata_r;
        end
    end

    assign PREADY  = pready_r;
    assign PRDATA  = prdata_r;
    assign PSLVERR = pslverr_r;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Scoreboard bench for apb_slave_mem: two instances (0 and 3 wait states) driven by randomized transfers.
module tb_apb_slave_mem;

`ifdef APB_SLV_RO_REGION_EN
    localparam bit RO_EN = 1'b1;
`else
    localparam bit RO_EN = 1'b0;
`endif

    typedef struct {
        logic [7:0] addr;
        logic       wr;
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    logic       clk;
    logic       preset  [2];
    logic       psel    [2];
    logic       penable [2];
    logic       pwrite  [2];
    logic [7:0] paddr   [2];
    logic [7:0] pwdata  [2];
    logic       pready  [2];
    logic [7:0] prdata  [2];
    logic       pslverr [2];

    exp_t       q0[$];
    exp_t       q1[$];
    logic [7:0] ref_mem [2][128];
    logic [7:0] pool [6] = '{8'h00, 8'h10, 8'h5F, 8'h60, 8'h7F, 8'h80};
    int         checks = 0;
    int         errors = 0;

    apb_slave_mem #(.WAIT_STATES(0)) u_dut0 (
        .PCLK(clk), .PRESET(preset[0]), .PSEL(psel[0]), .PENABLE(penable[0]),
        .PWRITE(pwrite[0]), .PADDR(paddr[0]), .PWDATA(pwdata[0]),
        .PREADY(pready[0]), .PRDATA(prdata[0]), .PSLVERR(pslverr[0])
    );

    apb_slave_mem #(.WAIT_STATES(3)) u_dut3 (
        .PCLK(clk), .PRESET(preset[1]), .PSEL(psel[1]), .PENABLE(penable[1]),
        .PWRITE(pwrite[1]), .PADDR(paddr[1]), .PWDATA(pwdata[1]),
        .PREADY(pready[1]), .PRDATA(prdata[1]), .PSLVERR(pslverr[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int p, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s port%0d: got %0h, expected %0h at %0t", name, p, act, exp, $time);
        end
    endtask

    // Reference model: the error rule, read value and memory update straight from the transfer fields.
    function automatic void expect_xfer(input int p, input logic wr, input logic [7:0] a, input logic [7:0] d);
        exp_t e;
        e.addr  = a;
        e.wr    = wr;
        e.err   = (a >= 8'd128) || (RO_EN && wr && a >= 8'd96);
        e.rdata = (!wr && !e.err) ? ref_mem[p][a[6:0]] : 8'h00;
        if (wr && !e.err) ref_mem[p][a[6:0]] = d;
        if (p == 0) q0.push_back(e);
        else        q1.push_back(e);
    endfunction

    function automatic void clear_model(input int p);
        for (int i = 0; i < 128; i++) ref_mem[p][i] = 8'h00;
    endfunction

    // Called at posedge+1; returns at posedge+1 right after the completion edge.
    task automatic xfer(input int p, input logic wr, input logic [7:0] a, input logic [7:0] d, input int ws);
        bit done;
        expect_xfer(p, wr, a, d);
        psel[p] = 1'b1; penable[p] = 1'b0; pwrite[p] = wr; paddr[p] = a; pwdata[p] = d;
        @(posedge clk); #1;
        penable[p] = 1'b1;
        paddr[p]   = 8'($urandom);
        pwdata[p]  = 8'($urandom);
        pwrite[p]  = 1'($urandom);
        done = 1'b0;
        for (int n = 1; n <= ws + 4 && !done; n++) begin
            @(negedge clk);
            chk("ready_timing", p, 32'(pready[p]), 32'(n == ws + 1));
            if (pready[p]) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout port%0d: got no PREADY, expected one within %0d cycles", p, ws + 4);
        end
        @(posedge clk); #1;
        psel[p] = 1'b0; penable[p] = 1'b0;
    endtask

    task automatic abort_xfer(input int p, input logic wr, input logic [7:0] a, input logic [7:0] d);
        psel[p] = 1'b1; penable[p] = 1'b0; pwrite[p] = wr; paddr[p] = a; pwdata[p] = d;
        @(posedge clk); #1;
        psel[p] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_ready", p, 32'(pready[p]), 32'd0);
        chk("abort_rdata", p, 32'(prdata[p]), 32'd0);
        chk("abort_err", p, 32'(pslverr[p]), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic run_port(input int p, input int ws);
        logic [7:0] a;
        preset[p] = 1'b1; psel[p] = 1'b0; penable[p] = 1'b0; pwrite[p] = 1'b0;
        paddr[p] = 8'h00; pwdata[p] = 8'h00;
        clear_model(p);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", p, 32'(pready[p]), 32'd0);
        chk("reset_rdata", p, 32'(prdata[p]), 32'd0);
        chk("reset_err", p, 32'(pslverr[p]), 32'd0);
        @(posedge clk); #1;
        preset[p] = 1'b0;

        xfer(p, 1'b1, 8'h10, 8'hA5, ws);
        xfer(p, 1'b0, 8'h10, 8'h00, ws);
        xfer(p, 1'b1, 8'h80, 8'h5A, ws);
        xfer(p, 1'b0, 8'h80, 8'h00, ws);
        xfer(p, 1'b0, 8'h00, 8'h00, ws);
        abort_xfer(p, 1'b1, 8'h20, 8'h33);
        xfer(p, 1'b0, 8'h20, 8'h00, ws);
        xfer(p, 1'b1, 8'h60, 8'h77, ws);
        xfer(p, 1'b0, 8'h60, 8'h00, ws);
        xfer(p, 1'b1, 8'h7F, 8'hC3, ws);
        xfer(p, 1'b0, 8'h7F, 8'h00, ws);

        // PENABLE high in IDLE must not start a transfer
        psel[p] = 1'b1; penable[p] = 1'b1; pwrite[p] = 1'b1; paddr[p] = 8'h10; pwdata[p] = 8'hEE;
        @(posedge clk);
        @(negedge clk);
        chk("violation_ready", p, 32'(pready[p]), 32'd0);
        @(posedge clk); #1;
        psel[p] = 1'b0; penable[p] = 1'b0;
        xfer(p, 1'b0, 8'h10, 8'h00, ws);

        // Asynchronous reset in the middle of an access phase
        psel[p] = 1'b1; penable[p] = 1'b0; pwrite[p] = 1'b0; paddr[p] = 8'h10;
        @(posedge clk); #1;
        penable[p] = 1'b1;
        #2;
        chk("pre_reset_ready", p, 32'(pready[p]), 32'(ws == 0));
        preset[p] = 1'b1;
        #1;
        chk("async_reset_ready", p, 32'(pready[p]), 32'd0);
        chk("async_reset_rdata", p, 32'(prdata[p]), 32'd0);
        chk("async_reset_err", p, 32'(pslverr[p]), 32'd0);
        psel[p] = 1'b0; penable[p] = 1'b0;
        clear_model(p);
        @(posedge clk); #1;
        preset[p] = 1'b0;
        xfer(p, 1'b0, 8'h10, 8'h00, ws);

        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 3) == 0) a = 8'($urandom);
            else                           a = pool[$urandom_range(0, 5)];
            if ($urandom_range(0, 7) == 0) abort_xfer(p, 1'($urandom), a, 8'($urandom));
            else                           xfer(p, 1'($urandom), a, 8'($urandom), ws);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
    endtask

    // Monitor: pops the scoreboard on every completing cycle.
    always @(negedge clk) begin
        exp_t e;
        bit   have;
        for (int p = 0; p < 2; p++) begin
            if (preset[p] === 1'b0 && psel[p] === 1'b1) begin
                if (penable[p] === 1'b0) begin
                    chk("setup_ready_low", p, 32'(pready[p]), 32'd0);
                end else if (pready[p] === 1'b1) begin
                    have = 1'b0;
                    if (p == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                    if (p == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                    if (!have) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp port%0d: got a completion, expected none", p);
                    end else begin
                        chk($sformatf("rdata@%0h", e.addr), p, 32'(prdata[p]), 32'(e.rdata));
                        chk($sformatf("pslverr@%0h", e.addr), p, 32'(pslverr[p]), 32'(e.err));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of stimulus, expected it before 200000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        fork
            run_port(0, 0);
            run_port(1, 3);
        join
        repeat (2) @(posedge clk);
        chk("queue0_drained", 0, 32'(q0.size()), 32'd0);
        chk("queue1_drained", 1, 32'(q1.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
